// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared widths and queue entry layout for the fib result path
package fib_pkg;

  localparam int FIB_W_N = 4;
  localparam int FIB_W_F = 10;

  typedef struct packed {
    logic [FIB_W_N-1:0] n;
    logic [FIB_W_F-1:0] f;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy counter and show-ahead head
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 14,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot, so a full queue still accepts
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (level <= LW'(DEPTH));
  end

endmodule

// File: rtl/fib_result_queue.sv
// rtl/fib_result_queue.sv - tags fib results with their job index and queues them
// for a valid/ready consumer, back-pressuring fib through pause.
module fib_result_queue
  import fib_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W_N   = FIB_W_N,
  parameter int W_F   = FIB_W_F,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fib_start,
  input  logic           fib_busy,
  input  logic           fib_done,
  input  logic [W_N-1:0] fib_n,
  input  logic [W_F-1:0] fib_f,
  output logic           fib_pause,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W_N-1:0] out_n,
  output logic [W_F-1:0] out_f,
  output logic [LW-1:0]  level,
  output logic           overflow,
  output logic           orphan
);

  logic [W_N-1:0]     tag;
  logic               tag_valid;
  logic               full;
  logic               empty;
  logic               accept;
  logic               pop;
  logic               tagged_done;
  logic               push;
  logic [W_N+W_F-1:0] head;

  assign fib_pause   = full;
  assign out_valid   = ~empty;
  assign {out_n, out_f} = head;

  assign accept      = fib_start & ~fib_busy & ~fib_pause;
  assign pop         = out_valid & out_ready;
  assign tagged_done = fib_done & tag_valid;
  assign push        = tagged_done & (~full | pop);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (W_N + W_F)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({tag, fib_f}),
    .pop       (pop),
    .head      (head),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  // a new job's tag wins over retiring the previous one in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      tag       <= '0;
      tag_valid <= 1'b0;
      overflow  <= 1'b0;
      orphan    <= 1'b0;
    end else begin
      if (accept) begin
        tag       <= fib_n;
        tag_valid <= 1'b1;
      end else if (push) begin
        tag_valid <= 1'b0;
      end
      if (tagged_done & full & ~pop) overflow <= 1'b1;
      if (fib_done & ~tag_valid)     orphan   <= 1'b1;
    end
  end

`ifdef FORMAL
  always @(posedge clk) begin
    if (!rst) begin
      assume (!(fib_done && !tag_valid));
      assume (!(fib_done && full && !pop));
      assert (level <= LW'(DEPTH));
      assert (!overflow);
      assert (!orphan);
      cover (full);
      cover (push && pop && full);
    end
  end
`endif

endmodule

// File: tb/tb_fib_result_queue.sv
// tb/tb_fib_result_queue.sv - randomized bench for fib_result_queue with a fib
// stand-in and a queue-level reference model
module tb_fib_result_queue;
  import fib_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       fib_start, fib_busy, fib_done, fib_pause;
  logic [3:0] fib_n, out_n;
  logic [9:0] fib_f, out_f;
  logic       out_valid, out_ready;
  logic [2:0] level;
  logic       overflow, orphan;

  always #5 clk = ~clk;

  fib_result_queue #(.DEPTH(DEPTH), .W_N(4), .W_F(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .fib_start (fib_start),
    .fib_busy  (fib_busy),
    .fib_done  (fib_done),
    .fib_n     (fib_n),
    .fib_f     (fib_f),
    .fib_pause (fib_pause),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_n     (out_n),
    .out_f     (out_f),
    .level     (level),
    .overflow  (overflow),
    .orphan    (orphan)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // reference model state
  entry_t     q[$];
  entry_t     popped[$];
  bit         m_tag_valid = 0;
  logic [3:0] m_tag = '0;
  bit         m_overflow = 0;
  bit         m_orphan = 0;

  // fib stand-in: n steps after accept, done pulse one cycle after last step
  bit         running = 0;
  int         steps = 0;
  logic [3:0] job_n = '0;
  bit         last_accept = 0;

  function automatic logic [9:0] fibv(input int n);
    int a = 1, b = 1, t;
    repeat (n) begin
      t = a + b;
      a = b;
      b = t;
    end
    return 10'(a);
  endfunction

  task automatic cycle(input bit start, input logic [3:0] n, input bit ready,
                       input bit force_d, input bit do_rst);
    bit     sd, m_pause, acc, f_acc, pop;
    entry_t e;
    sd        = running && steps == 0;
    rst       = do_rst;
    fib_start = start;
    fib_n     = n;
    out_ready = ready;
    fib_busy  = running && steps != 0;
    fib_done  = sd || force_d;
    fib_f     = force_d ? 10'($urandom) : fibv(job_n);
    #1;
    m_pause = (q.size() == DEPTH);
    check("level", level, q.size());
    check("pause", fib_pause, m_pause);
    check("valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("head_n", out_n, q[0].n);
      check("head_f", out_f, q[0].f);
    end
    check("overflow", overflow, m_overflow);
    check("orphan", orphan, m_orphan);
    acc   = start && !fib_busy && !m_pause;
    f_acc = start && !fib_busy && !fib_pause;
    pop   = ready && q.size() != 0;
    last_accept = f_acc && !do_rst;
    if (do_rst) begin
      q.delete();
      m_tag_valid = 0;
      m_tag       = '0;
      m_overflow  = 0;
      m_orphan    = 0;
    end else begin
      if (pop && out_valid) popped.push_back(entry_t'({out_n, out_f}));
      e.n = m_tag;
      e.f = fib_f;
      if (pop) void'(q.pop_front());
      if (fib_done) begin
        if (!m_tag_valid) m_orphan = 1;
        else if (q.size() < DEPTH) begin
          q.push_back(e);
          m_tag_valid = 0;
        end else m_overflow = 1;
      end
      if (acc) begin
        m_tag       = n;
        m_tag_valid = 1;
      end
    end
    if (sd) running = 0;
    else if (running && !fib_pause) steps--;
    if (f_acc) begin
      running = 1;
      steps   = n;
      job_n   = n;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic bit pick(input int rmode);
    return (rmode == 2) ? bit'($urandom % 2) : bit'(rmode);
  endfunction

  task automatic idle(input int cyc, input int rmode);
    repeat (cyc) cycle(0, 0, pick(rmode), 0, 0);
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic accept_job(input logic [3:0] n, input int rmode);
    int k = 0;
    do begin
      cycle(1, n, pick(rmode), 0, 0);
      k++;
    end while (!last_accept && k < 200);
    if (!last_accept) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int rmode);
    int k = 0;
    while (running && k < 200) begin
      cycle(0, 0, pick(rmode), 0, 0);
      k++;
    end
    if (running) check("idle_timeout", 0, 1);
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 50) begin
      cycle(0, 0, 1, 0, 0);
      k++;
    end
    if (q.size() != 0) check("drain_timeout", 0, 1);
  endtask

  task automatic fill_with_tag_pending();
    repeat (3) begin
      accept_job(0, 0);
      wait_idle(0);
    end
    accept_job(1, 0);
    accept_job(9, 0);
    check("fill_level", level, 4);
  endtask

  initial begin
    int exp_n[5] = '{0, 1, 2, 3, 4};
    int exp_f[5] = '{1, 1, 2, 3, 5};
    rst = 1; fib_start = 0; fib_busy = 0; fib_done = 0;
    fib_n = '0; fib_f = '0; out_ready = 0;
    @(posedge clk);
    #1;
    do_reset();
    check("rst_level", level, 0);
    check("rst_valid", out_valid, 0);
    check("rst_pause", fib_pause, 0);
    check("rst_overflow", overflow, 0);
    check("rst_orphan", orphan, 0);

    // single job n=5
    popped.delete();
    accept_job(5, 1);
    wait_idle(1);
    idle(3, 1);
    check("t1_count", popped.size(), 1);
    if (popped.size() >= 1) begin
      check("t1_n", popped[0].n, 5);
      check("t1_f", popped[0].f, 8);
    end
    check("t1_level", level, 0);

    // fill to full, start held off
    popped.delete();
    for (int i = 0; i < 4; i++) begin
      accept_job(4'(i), 0);
      wait_idle(0);
    end
    check("t2_level", level, 4);
    check("t2_pause", fib_pause, 1);
    repeat (3) cycle(1, 4, 0, 0, 0);
    check("t2_held", running, 0);

    // one pop releases pause, held job 4 completes
    cycle(1, 4, 1, 0, 0);
    check("t3_popcount", popped.size(), 1);
    accept_job(4, 0);
    wait_idle(0);
    idle(1, 0);
    check("t3_level", level, 4);
    check("t3_head_n", out_n, 1);
    drain();
    check("t3_total", popped.size(), 5);
    for (int i = 0; i < 5 && i < popped.size(); i++) begin
      check("t3_seq_n", popped[i].n, exp_n[i]);
      check("t3_seq_f", popped[i].f, exp_f[i]);
    end

    // forced done while full: dropped, then push&pop
    do_reset();
    fill_with_tag_pending();
    cycle(0, 0, 0, 1, 0);
    check("t4_overflow", overflow, 1);
    check("t4_level", level, 4);
    check("t4_head_n", out_n, 0);
    check("t4_head_f", out_f, 1);
    do_reset();
    wait_idle(0);
    do_reset();
    fill_with_tag_pending();
    cycle(0, 0, 1, 1, 0);
    check("t4b_level", level, 4);
    check("t4b_overflow", overflow, 0);
    do_reset();
    wait_idle(0);
    do_reset();

    // reset while busy: late done becomes an orphan
    accept_job(6, 0);
    idle(2, 0);
    cycle(0, 0, 0, 0, 1);
    check("t5_level", level, 0);
    wait_idle(0);
    idle(1, 0);
    check("t5_orphan", orphan, 1);
    check("t5_level2", level, 0);
    check("t5_valid", out_valid, 0);

    // ten back-to-back jobs, random consumer
    do_reset();
    popped.delete();
    for (int i = 0; i < 10; i++) accept_job(4'(i), 2);
    wait_idle(2);
    idle(1, 2);
    drain();
    check("t6_count", popped.size(), 10);
    for (int i = 0; i < 10 && i < popped.size(); i++) begin
      check("t6_n", popped[i].n, i);
      check("t6_f", popped[i].f, fibv(i));
    end
    if (popped.size() == 10) check("t6_f9", popped[9].f, 55);
    check("t6_overflow", overflow, 0);

    // random soak including stray done pulses
    do_reset();
    repeat (400) begin
      bit fd;
      fd = (($urandom % 32) == 0) && !(running && steps == 0);
      cycle(bit'($urandom % 2), 4'($urandom % 10), bit'($urandom % 2), fd, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
